// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// 16-entry receive FIFO sitting between the UART serial receiver and the
// register interface. Each word holds a received character in
// [WIDTH-1:2], a parity-error flag in [1] and a framing-error flag in [0].
// The block tracks occupancy, sticky overrun/underrun conditions and an
// aggregate "error present in FIFO" flag for the line status register.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   wb_rst_i      asynchronous active-high reset
//   data_in       word to write
//   push          write strobe, one word per cycle while high
//   pop           read strobe, one word per cycle while high
//   fifo_reset    synchronous flush of pointers, count, flags and error bits
//   reset_status  synchronous clear of overrun/underrun
//   data_out      word at the head of the FIFO (undefined while count == 0)
//   count         number of stored words, 0..16
//   overrun       sticky: push attempted while full
//   underrun      sticky: pop attempted while empty
//   error_bit     high while any stored word has bit [1] or [0] set
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned COUNT_W = 5
) (
    input  logic               clk,
    input  logic               wb_rst_i,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               push,
    input  logic               pop,
    input  logic               fifo_reset,
    input  logic               reset_status,
    output logic [WIDTH-1:0]   data_out,
    output logic [COUNT_W-1:0] count,
    output logic               overrun,
    output logic               underrun,
    output logic               error_bit
);

    localparam int unsigned PtrW  = 4;
    localparam int unsigned DataW = WIDTH - 2;

    // Character bits are kept apart from the error flags: only the flags
    // need a reset/flush, so the character storage stays reset-free.
    logic [DataW-1:0]   mem_data [DEPTH];
    logic [1:0]         err_q    [DEPTH];

    logic [PtrW-1:0]    top_q, top_d;
    logic [PtrW-1:0]    bottom_q, bottom_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               overrun_q, overrun_d;
    logic               underrun_q, underrun_d;

    logic full;
    logic empty;
    logic do_write;
    logic do_read;
    logic overrun_evt;
    logic underrun_evt;
    logic err_any;

    assign full  = (count_q == COUNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A simultaneous pop frees the head slot, so a full FIFO still accepts
    // the write. A pop on an empty FIFO is ignored even when paired with a
    // push.
    assign do_write     = push & (~full | pop);
    assign do_read      = pop & ~empty;
    assign overrun_evt  = push & ~pop & full;
    assign underrun_evt = pop & ~push & empty;

    // -----------------------------------------------------------------------
    // Next-state for pointers, occupancy and sticky flags
    // -----------------------------------------------------------------------
    always_comb begin
        top_d      = top_q;
        bottom_d   = bottom_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;

        if (fifo_reset) begin
            top_d      = '0;
            bottom_d   = '0;
            count_d    = '0;
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end else begin
            if (do_write) begin
                top_d = top_q + PtrW'(1);
            end
            if (do_read) begin
                bottom_d = bottom_q + PtrW'(1);
            end
            count_d = count_q + COUNT_W'(do_write) - COUNT_W'(do_read);

            // A fresh event in the same cycle beats reset_status.
            if (reset_status) begin
                overrun_d  = 1'b0;
                underrun_d = 1'b0;
            end
            if (overrun_evt) begin
                overrun_d = 1'b1;
            end
            if (underrun_evt) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            top_q      <= '0;
            bottom_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            top_q      <= top_d;
            bottom_q   <= bottom_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (do_write && !fifo_reset) begin
            mem_data[top_q] <= data_in[WIDTH-1:2];
        end
    end

    // Error flags of an entry are cleared when it is popped or flushed, so
    // every unoccupied entry holds zero flags. When full with push and pop
    // together, top == bottom and the incoming word's flags win.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                err_q[i] <= 2'b00;
            end
        end else if (fifo_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                err_q[i] <= 2'b00;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (do_write && (top_q == PtrW'(i))) begin
                    err_q[i] <= data_in[1:0];
                end else if (do_read && (bottom_q == PtrW'(i))) begin
                    err_q[i] <= 2'b00;
                end
            end
        end
    end

    // Unoccupied entries always carry zero flags, so a plain OR over the
    // whole array equals the OR over occupied entries.
    always_comb begin
        err_any = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            err_any = err_any | (|err_q[i]);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign data_out  = {mem_data[bottom_q], err_q[bottom_q]};
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign underrun  = underrun_q;
    assign error_bit = err_any;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo. A queue-based reference model holds
// the expected FIFO contents and sticky flags; the head word is compared
// before every pop edge. A table of vectors with explicit expected
// count/flag values covers the basic sequences, followed by hand-written
// sequences for full/overrun, pointer wrap, flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic       clk;
    logic       wb_rst_i;
    logic [9:0] data_in;
    logic       push;
    logic       pop;
    logic       fifo_reset;
    logic       reset_status;
    logic [9:0] data_out;
    logic [4:0] count;
    logic       overrun;
    logic       underrun;
    logic       error_bit;

    uart_rx_fifo #(
        .WIDTH   (10),
        .DEPTH   (16),
        .COUNT_W (5)
    ) dut (
        .clk          (clk),
        .wb_rst_i     (wb_rst_i),
        .data_in      (data_in),
        .push         (push),
        .pop          (pop),
        .fifo_reset   (fifo_reset),
        .reset_status (reset_status),
        .data_out     (data_out),
        .count        (count),
        .overrun      (overrun),
        .underrun     (underrun),
        .error_bit    (error_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model
    logic [9:0] sb [$];
    bit         m_ov;
    bit         m_un;

    typedef struct packed {
        bit       ps;
        bit       pp;
        bit       fr;
        bit       rs;
        bit [9:0] din;
        bit [4:0] e_count;
        bit       e_ov;
        bit       e_un;
        bit       e_err;
    } vec_t;

    localparam int NVec = 16;
    vec_t vecs [NVec];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_err();
        bit e = 1'b0;
        foreach (sb[i]) e = e | (|sb[i][1:0]);
        return e;
    endfunction

    task automatic model_clear();
        sb.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    // One clock cycle of stimulus, model update and post-edge check.
    task automatic step(input bit ps, input bit pp, input bit fr, input bit rs,
                        input logic [9:0] din);
        int sz;
        bit ovev;
        bit unev;
        @(negedge clk);
        push         = ps;
        pop          = pp;
        fifo_reset   = fr;
        reset_status = rs;
        data_in      = din;
        #1;
        sz = sb.size();
        if (pp && !fr && sz > 0) chk("head", data_out, sb[0]);
        if (fr) begin
            model_clear();
        end else begin
            ovev = ps && !pp && (sz == 16);
            unev = pp && !ps && (sz == 0);
            if (rs) begin
                m_ov = 1'b0;
                m_un = 1'b0;
            end
            if (ovev) m_ov = 1'b1;
            if (unev) m_un = 1'b1;
            if (pp && sz > 0) void'(sb.pop_front());
            if (ps && sb.size() < 16) sb.push_back(din);
        end
        @(posedge clk);
        #1;
        push         = 1'b0;
        pop          = 1'b0;
        fifo_reset   = 1'b0;
        reset_status = 1'b0;
        chk("count", count, sb.size());
        chk("overrun", overrun, m_ov);
        chk("underrun", underrun, m_un);
        chk("error_bit", error_bit, model_err());
    endtask

    initial begin
        logic [9:0] w;

        wb_rst_i     = 1'b1;
        push         = 1'b0;
        pop          = 1'b0;
        fifo_reset   = 1'b0;
        reset_status = 1'b0;
        data_in      = '0;
        model_clear();

        // ps pp fr rs din        cnt ov un err
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h155, 5'd1, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h2A8, 5'd2, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h0FC, 5'd3, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h101, 5'd1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h200, 5'd2, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h3FE, 5'd1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 10'h000, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h0AC, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 5'd0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_count", count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_error_bit", error_bit, 0);
        @(negedge clk);
        wb_rst_i = 1'b0;

        // Table-driven basic sequences
        for (int i = 0; i < NVec; i++) begin
            step(vecs[i].ps, vecs[i].pp, vecs[i].fr, vecs[i].rs, vecs[i].din);
            chk("vec_count", count, vecs[i].e_count);
            chk("vec_overrun", overrun, vecs[i].e_ov);
            chk("vec_underrun", underrun, vecs[i].e_un);
            chk("vec_error_bit", error_bit, vecs[i].e_err);
        end

        // 17 pushes: the last is discarded and sets overrun
        for (int i = 0; i < 17; i++) begin
            w = 10'((i * 68 + 12)) & 10'h3FC;
            step(1'b1, 1'b0, 1'b0, 1'b0, w);
        end
        chk("full_count", count, 16);
        chk("full_overrun", overrun, 1);
        // Overrun event in the same cycle as reset_status keeps the flag
        step(1'b1, 1'b0, 1'b0, 1'b1, 10'h3FC);
        chk("ov_event_wins", overrun, 1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
        chk("drained_count", count, 0);

        // Underrun, event-wins over reset_status, then clear
        step(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
        chk("un_set", underrun, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 10'h000);
        chk("un_event_wins", underrun, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        chk("status_clear_un", underrun, 0);
        chk("status_clear_ov", overrun, 0);

        // Fill, then 40 cycles of simultaneous push/pop across pointer wrap
        for (int i = 0; i < 16; i++) begin
            w = 10'($urandom_range(0, 1023));
            step(1'b1, 1'b0, 1'b0, 1'b0, w);
        end
        for (int i = 0; i < 40; i++) begin
            w = 10'($urandom_range(0, 1023));
            step(1'b1, 1'b1, 1'b0, 1'b0, w);
        end
        chk("wrap_count", count, 16);
        chk("wrap_overrun", overrun, 0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);

        // Five words with one error, then flush; a following word reads back
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h110);
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h222);
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h334);
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h048);
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h15C);
        chk("pre_flush_err", error_bit, 1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 10'h3FF);
        chk("flush_count", count, 0);
        chk("flush_err", error_bit, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h0AC);
        chk("post_flush_word", data_out, 10'h0AC);
        step(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);

        // Asynchronous reset mid-cycle clears everything immediately
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h203);
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h1F0);
        @(negedge clk);
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_err", error_bit, 0);
        model_clear();
        @(negedge clk);
        wb_rst_i = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h2F4);
        chk("post_rst_word", data_out, 10'h2F4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
